// File: rtl/fb_scan_arbiter.sv
// Single-port frame buffer arbiter: VGA scan-out reads own even-column slots, Sobel writes take the rest; output is 2x upscaled.
// Optional macro FB_DBUF_EN adds double buffering (bank MSB on mem_addr, swap requested by wr_frame_done).
module fb_scan_arbiter #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int AW       = 17,
  parameter int DW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
`ifdef FB_DBUF_EN
  input  logic          wr_frame_done,
  output logic [AW:0]   mem_addr,
`else
  output logic [AW-1:0] mem_addr,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_out,
  output logic          pix_de,
  output logic [15:0]   wr_stall_cnt,
  output logic          wr_oob
);

  localparam logic [10:0]   H_ACT     = 11'(H_ACTIVE);
  localparam logic [9:0]    V_ACT     = 10'(V_ACTIVE);
  localparam logic [AW-1:0] PIX_TOTAL = AW'(IMG_W * IMG_H);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_vis1, r_vis2;
  logic          r_even1, r_even2;
  logic          w_frame_start, w_clear;
  logic          w_visible, w_read_slot;
  logic          w_wr_acc, w_wr_oob;
  logic [AW-1:0] w_rd_addr;

  assign w_frame_start = (h_cnt == 11'd0) && (v_cnt == 10'd0);
  assign w_clear       = (r_state == RUN) && w_frame_start;
  assign w_visible     = (r_state == RUN) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign w_read_slot   = w_visible && !h_cnt[0];

  // Row base times 320 is (row << 8) + (row << 6); the halved counters give the 2x upscale.
  assign w_rd_addr = AW'({v_cnt[9:1], 8'd0}) + AW'({v_cnt[9:1], 6'd0}) + AW'(h_cnt[10:1]);

  // NOTE: wr_ready is gated by rst so a write offered during reset stalls instead of being lost.
  assign wr_ready = !rst && (r_state == RUN) && !w_read_slot;
  assign w_wr_acc = wr_valid && wr_ready;
  assign w_wr_oob = (wr_addr >= PIX_TOTAL);

`ifdef FB_DBUF_EN
  logic          r_front, r_swap_pending;
  logic          w_front;
  logic [AW:0]   w_rd_mem_addr, w_wr_mem_addr;

  // The read issued on the swap cycle already belongs to the new frame.
  assign w_front       = r_front ^ (w_clear && r_swap_pending);
  assign w_rd_mem_addr = {w_front, w_rd_addr};
  assign w_wr_mem_addr = {~w_front, wr_addr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (w_clear) begin
      r_front        <= w_front;
      r_swap_pending <= wr_frame_done;
    end else if (wr_frame_done) begin
      r_swap_pending <= 1'b1;
    end
  end
`else
  logic [AW-1:0] w_rd_mem_addr, w_wr_mem_addr;

  assign w_rd_mem_addr = w_rd_addr;
  assign w_wr_mem_addr = wr_addr;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WAIT_FRAME;
      r_vis1       <= 1'b0;
      r_vis2       <= 1'b0;
      r_even1      <= 1'b0;
      r_even2      <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      pix_out      <= '0;
      pix_de       <= 1'b0;
      wr_stall_cnt <= '0;
      wr_oob       <= 1'b0;
    end else begin
      case (r_state)
        WAIT_FRAME: if (w_frame_start) r_state <= RUN;
        RUN:        r_state <= RUN;
        default:    r_state <= WAIT_FRAME;
      endcase

      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (w_read_slot) begin
        mem_en   <= 1'b1;
        mem_addr <= w_rd_mem_addr;
      end else if (w_wr_acc) begin
        if (w_wr_oob) begin
          wr_oob <= 1'b1;
        end else begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= w_wr_mem_addr;
          mem_wdata <= wr_data;
        end
      end

      // Two stages cover the registered issue plus the BRAM read latency.
      r_vis1  <= w_visible;
      r_even1 <= !h_cnt[0];
      r_vis2  <= r_vis1;
      r_even2 <= r_even1;
      pix_de  <= r_vis2;
      if (!r_vis2) begin
        pix_out <= '0;
      end else if (r_even2) begin
        pix_out <= mem_rdata;
      end

      if (w_clear) begin
        wr_stall_cnt <= '0;
      end else if (wr_valid && !wr_ready && (wr_stall_cnt != 16'hFFFF)) begin
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter: a frame-level reference model predicts memory ops and pixels, a monitor compares.
module tb_fb_scan_arbiter;

  localparam int AW   = 17;
  localparam int DW   = 8;
  localparam int NPIX = 320 * 240;
  localparam int MEMN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   h_cnt;
  logic [9:0]    v_cnt;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pix_out;
  logic          pix_de;
  logic [15:0]   wr_stall_cnt;
  logic          wr_oob;

  always #5 clk = ~clk;

  fb_scan_arbiter dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_out(pix_out), .pix_de(pix_de),
    .wr_stall_cnt(wr_stall_cnt), .wr_oob(wr_oob)
  );

  // Frame buffer BRAM seen by the DUT: one-cycle read latency, preloaded with a pattern.
  logic [7:0] bram [0:MEMN-1];
  bit         bram_ready = 1'b0;
  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < MEMN; i++) bram[i] <= 8'(i ^ (i >> 7));
      bram_ready <= 1'b1;
    end else if (mem_en === 1'b1) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  typedef struct { int cyc; bit we; int addr; int data; } mem_exp_t;
  typedef struct { int cyc; int data; } pix_exp_t;
  mem_exp_t mq[$];
  pix_exp_t pq[$];

  int errors = 0, checks = 0;
  int cyc = 0;

  // Reference model state: image contents, run flag, counters as visible in the current cycle.
  logic [7:0] ref_img [0:MEMN-1];
  bit  m_run = 0, m_oob = 0;
  int  m_stall = 0, m_pix = 0;
  bit  e_chk = 0, e_rst = 1, e_ready = 0, e_oob = 0;
  int  e_stall = 0;
  bit  last_acc = 0;
  bit  w_pend = 0;
  int  w_a = 0, w_d = 0;
  int  n_act = 0, n_blank = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input int h, input int v, input bit wv, input int wa, input int wd);
    bit vis, slot, frame0;
    int ra;
    @(posedge clk);
    #1;
    rst      = r;
    h_cnt    = 11'(h);
    v_cnt    = 10'(v);
    wr_valid = wv;
    wr_addr  = AW'(wa);
    wr_data  = DW'(wd);
    cyc++;
    e_chk   = (cyc > 1);
    e_rst   = r;
    e_stall = m_stall;
    e_oob   = m_oob;
    last_acc = 0;
    if (r) begin
      m_run = 0; m_stall = 0; m_oob = 0; m_pix = 0; e_ready = 0;
      while (mq.size() > 0 && mq[$].cyc > cyc) void'(mq.pop_back());
      while (pq.size() > 0 && pq[$].cyc > cyc) void'(pq.pop_back());
    end else begin
      frame0  = (h == 0) && (v == 0);
      vis     = m_run && (h < 640) && (v < 480);
      slot    = vis && (h % 2 == 0);
      e_ready = m_run && !slot;
      last_acc = wv && e_ready;
      if (m_run && frame0) m_stall = 0;
      else if (wv && !e_ready && m_stall < 65535) m_stall++;
      if (slot) begin
        ra = (v / 2) * 320 + h / 2;
        mq.push_back('{cyc: cyc + 1, we: 1'b0, addr: ra, data: 0});
        m_pix = int'(ref_img[ra]);
      end else if (!vis) begin
        m_pix = 0;
      end
      if (vis) pq.push_back('{cyc: cyc + 3, data: m_pix});
      if (last_acc) begin
        if (wa < NPIX) begin
          mq.push_back('{cyc: cyc + 1, we: 1'b1, addr: wa, data: wd});
          ref_img[wa] = 8'(wd);
        end else begin
          m_oob = 1;
        end
      end
      if (!m_run && frame0) m_run = 1;
    end
  endtask

  // Writer that holds its offer until accepted; pct is the chance of a new offer when idle.
  task automatic line(input int v, input int h0, input int h1, input int pct);
    for (int h = h0; h <= h1; h++) begin
      if (!w_pend && pct > 0 && $urandom_range(0, 99) < pct) begin
        w_pend = 1;
        w_a    = $urandom_range(0, NPIX - 1);
        w_d    = $urandom_range(0, 255);
      end
      step(0, h, v, w_pend, w_a, w_d);
      if (last_acc) w_pend = 0;
    end
  endtask

  always @(negedge clk) begin
    mem_exp_t me;
    pix_exp_t pe;
    bit due;
    if (e_chk) begin
      if (!e_rst) check("wr_ready", 32'(wr_ready), 32'(e_ready));
      check("wr_stall_cnt", 32'(wr_stall_cnt), 32'(e_stall));
      check("wr_oob", 32'(wr_oob), 32'(e_oob));
      due = (mq.size() > 0) && (mq[0].cyc == cyc);
      check("mem_en", 32'(mem_en), 32'(due));
      if (due) begin
        me = mq.pop_front();
        if (mem_en === 1'b1) begin
          check("mem_we", 32'(mem_we), 32'(me.we));
          check("mem_addr", 32'(mem_addr), me.addr);
          if (me.we) check("mem_wdata", 32'(mem_wdata), me.data);
        end
      end
      due = (pq.size() > 0) && (pq[0].cyc == cyc);
      check("pix_de", 32'(pix_de), 32'(due));
      if (due) begin
        pe = pq.pop_front();
        check("pix_out", 32'(pix_out), pe.data);
      end else begin
        check("pix_out_blank", 32'(pix_out), 32'd0);
      end
      if (!e_rst && wr_valid && wr_ready) begin
        if (h_cnt < 11'd640) n_act++;
        else                 n_blank++;
      end
    end
  end

  initial begin
    rst = 1'b1; h_cnt = '0; v_cnt = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < MEMN; i++) ref_img[i] = 8'(i ^ (i >> 7));

    repeat (3) step(1, 0, 0, 0, 0, 0);
    line(3, 5, 40, 0);             // waiting for frame start
    line(0, 0, 0, 0);              // (0,0) seen: RUN from next cycle
    line(0, 1, 799, 40);
    line(1, 0, 799, 40);

    // Plant 0xA5 at 1010 via the writer, then scan row 7 across columns 100/101.
    while (w_pend) line(490, 700, 700, 0);
    w_pend = 1; w_a = 1010; w_d = 8'hA5;
    line(490, 701, 701, 0);
    line(7, 96, 106, 0);

    // Writer saturated through an active line right after a frame start.
    line(0, 0, 0, 100);
    n_act = 0; n_blank = 0;
    line(7, 0, 799, 100);
    @(negedge clk); #1;
    check("writes_active_line", n_act, 320);
    check("writes_blanking", n_blank, 160);
    check("stall_after_line", 32'(wr_stall_cnt), 320);

    for (int k = 0; k < 6; k++) line($urandom_range(0, 524), 0, 799, $urandom_range(20, 90));
    line(0, 0, 799, 60);

    // Out-of-range write then the last valid address.
    while (w_pend) line(490, 700, 700, 0);
    w_pend = 1; w_a = NPIX; w_d = 8'h33;
    line(490, 706, 706, 0);
    w_pend = 1; w_a = NPIX - 1; w_d = 8'h5A;
    line(490, 707, 707, 0);
    line(490, 708, 720, 50);
    line(10, 0, 400, 50);

    // Reset in the middle of an active line with reads in flight.
    line(200, 290, 299, 50);
    step(1, 300, 200, 0, 0, 0);
    w_pend = 0;
    line(200, 301, 340, 0);
    line(0, 0, 0, 0);
    line(0, 1, 799, 50);
    line(1, 0, 799, 50);

    line(500, 0, 20, 0);
    line(500, 21, 30, 0);
    check("mem_queue_drained", mq.size(), 0);
    check("pix_queue_drained", pq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
